hazard_stall_ctrl: RTL and testbench



---
 rtl/hazard_stall_ctrl.sv | 126 ++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Decode-side sequencing controller. A shift-register scoreboard follows the
//   register writes of issued instructions through EX/MEM. A decode read that
//   hits a pending write holds PC/IF/ID and shifts a bubble into the
//   scoreboard. The stall vector is arbitrated in the order flush, external
//   stall, RAW hazard, normal issue.
// Ports
//   clk, rst            clock; synchronous active-high reset
//   id_valid_i          decode holds a valid instruction
//   reg{1,2}_read_i     register read enables
//   reg{1,2}_addr_i     register read addresses
//   wreg_i, wd_i        decoded register write enable / destination
//   stallreq_ext_i      external stall request (freezes the whole pipe)
//   flush_i             drop every in-flight instruction
//   stall_o             {WB,MEM,EX,ID,IF,PC} stall vector
//   issue_o             decode advances into EX this cycle
//   hazard_o            RAW hazard stall active this cycle
//   busy_o              any scoreboard slot valid
//   stall_cnt_o         saturating count of hazard-stall cycles

// Per-slot comparator: one instance per scoreboard slot.
module haz_slot_cmp (
  input  logic       pend_v,
  input  logic [4:0] pend_a,
  input  logic [4:0] rd_addr1,
  input  logic [4:0] rd_addr2,
  output logic       hit1,
  output logic       hit2
);
  assign hit1 = pend_v & (pend_a == rd_addr1);
  assign hit2 = pend_v & (pend_a == rd_addr2);
endmodule

module hazard_stall_ctrl #(
  parameter int HAZ_DEPTH = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid_i,
  input  logic             reg1_read_i,
  input  logic [4:0]       reg1_addr_i,
  input  logic             reg2_read_i,
  input  logic [4:0]       reg2_addr_i,
  input  logic             wreg_i,
  input  logic [4:0]       wd_i,
  input  logic             stallreq_ext_i,
  input  logic             flush_i,
  output logic [5:0]       stall_o,
  output logic             issue_o,
  output logic             hazard_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // slot 0 = EX, slot 1 = MEM, ...
  logic [HAZ_DEPTH-1:0]      pend_v;
  logic [HAZ_DEPTH-1:0][4:0] pend_a;
  logic [HAZ_DEPTH-1:0]      hit1, hit2;
  logic                      match1, match2, raw;
  logic                      haz;

  genvar k;
  generate
    for (k = 0; k < HAZ_DEPTH; k++) begin : g_slot
      haz_slot_cmp u_cmp (
        .pend_v   (pend_v[k]),
        .pend_a   (pend_a[k]),
        .rd_addr1 (reg1_addr_i),
        .rd_addr2 (reg2_addr_i),
        .hit1     (hit1[k]),
        .hit2     (hit2[k])
      );
    end
  endgenerate

  // r0 is hardwired zero, so it can never carry a dependency.
  assign match1 = reg1_read_i & (|reg1_addr_i) & (|hit1);
  assign match2 = reg2_read_i & (|reg2_addr_i) & (|hit2);
  assign raw    = id_valid_i & (match1 | match2);

  always_comb begin
    stall_o  = 6'b000000;
    issue_o  = 1'b0;
    haz      = 1'b0;
    if (rst) begin
      stall_o = 6'b000000;
    end else if (flush_i) begin
      stall_o = 6'b000000;
    end else if (stallreq_ext_i) begin
      stall_o = 6'b111111;
    end else if (raw) begin
      stall_o = 6'b000111;
      haz     = 1'b1;
    end else begin
      issue_o = id_valid_i;
    end
  end

  assign hazard_o = haz;
  assign busy_o   = ~rst & (|pend_v);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v      <= '0;
      pend_a      <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (flush_i) begin
        pend_v <= '0;
      end else if (!stallreq_ext_i) begin
        // A hazard cycle shifts in a bubble, which bounds any hazard to
        // HAZ_DEPTH consecutive cycles. The oldest slot falls off the end.
        pend_v[0] <= ~raw & id_valid_i & wreg_i & (|wd_i);
        pend_a[0] <= raw ? 5'd0 : wd_i;
        for (int i = 1; i < HAZ_DEPTH; i++) begin
          pend_v[i] <= pend_v[i-1];
          pend_a[i] <= pend_a[i-1];
        end
      end
      if (haz && (stall_cnt_o != {CNT_W{1'b1}}))
        stall_cnt_o <= stall_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;
  localparam int HD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_valid_i = 0, reg1_read_i = 0, reg2_read_i = 0, wreg_i = 0;
  logic stallreq_ext_i = 0, flush_i = 0;
  logic [4:0] reg1_addr_i = 0, reg2_addr_i = 0, wd_i = 0;

  logic [5:0]  stall_o, s_stall;
  logic        issue_o, hazard_o, busy_o, s_issue, s_hazard, s_busy;
  logic [15:0] stall_cnt_o;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.HAZ_DEPTH(HD), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
    .reg1_read_i(reg1_read_i), .reg1_addr_i(reg1_addr_i),
    .reg2_read_i(reg2_read_i), .reg2_addr_i(reg2_addr_i),
    .wreg_i(wreg_i), .wd_i(wd_i), .stallreq_ext_i(stallreq_ext_i),
    .flush_i(flush_i), .stall_o(stall_o), .issue_o(issue_o),
    .hazard_o(hazard_o), .busy_o(busy_o), .stall_cnt_o(stall_cnt_o));

  // Narrow-counter instance sharing the same stimulus, for saturation.
  hazard_stall_ctrl #(.HAZ_DEPTH(HD), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i),
    .reg1_read_i(reg1_read_i), .reg1_addr_i(reg1_addr_i),
    .reg2_read_i(reg2_read_i), .reg2_addr_i(reg2_addr_i),
    .wreg_i(wreg_i), .wd_i(wd_i), .stallreq_ext_i(stallreq_ext_i),
    .flush_i(flush_i), .stall_o(s_stall), .issue_o(s_issue),
    .hazard_o(s_hazard), .busy_o(s_busy), .stall_cnt_o(s_cnt));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // In-flight destinations, youngest first; -1 = nothing pending.
  int q[$];
  int m_cnt16 = 0, m_cnt2 = 0;
  bit mon_en = 0;

  function automatic bit m_reads(input logic en, input logic [4:0] a);
    if (!en || a == 0) return 0;
    foreach (q[i]) if (q[i] == int'(a)) return 1;
    return 0;
  endfunction

  function automatic bit m_raw();
    return id_valid_i && (m_reads(reg1_read_i, reg1_addr_i) ||
                          m_reads(reg2_read_i, reg2_addr_i));
  endfunction

  function automatic bit m_hazard();
    return !rst && !flush_i && !stallreq_ext_i && m_raw();
  endfunction

  function automatic int m_stall();
    if (rst || flush_i) return 0;
    if (stallreq_ext_i) return 63;
    if (m_raw()) return 7;
    return 0;
  endfunction

  function automatic bit m_busy();
    if (rst) return 0;
    foreach (q[i]) if (q[i] >= 0) return 1;
    return 0;
  endfunction

  task automatic q_clear();
    q.delete();
    for (int i = 0; i < HD; i++) q.push_back(-1);
  endtask

  initial q_clear();

  always @(posedge clk) begin
    bit h, r;
    h = m_hazard();
    r = m_raw();
    if (rst) begin
      q_clear();
      m_cnt16 = 0;
      m_cnt2  = 0;
      mon_en  = 1;
    end else begin
      if (h) begin
        if (m_cnt16 < 65535) m_cnt16++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (flush_i) q_clear();
      else if (!stallreq_ext_i) begin
        if (r) q.push_front(-1);
        else if (id_valid_i && wreg_i && wd_i != 0) q.push_front(int'(wd_i));
        else q.push_front(-1);
        void'(q.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("stall_o",  int'(stall_o),  m_stall());
      chk("hazard_o", int'(hazard_o), int'(m_hazard()));
      chk("issue_o",  int'(issue_o),
          int'(!rst && !flush_i && !stallreq_ext_i && !m_raw() && id_valid_i));
      chk("busy_o",   int'(busy_o),   int'(m_busy()));
      chk("stall_cnt_o", int'(stall_cnt_o), m_cnt16);
      chk("sat_cnt",  int'(s_cnt),    m_cnt2);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic v, input logic r1, input logic [4:0] a1,
                      input logic r2, input logic [4:0] a2,
                      input logic w, input logic [4:0] d,
                      input logic ext, input logic fl);
    @(posedge clk); #1;
    id_valid_i = v; reg1_read_i = r1; reg1_addr_i = a1;
    reg2_read_i = r2; reg2_addr_i = a2; wreg_i = w; wd_i = d;
    stallreq_ext_i = ext; flush_i = fl;
    @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] d);
    step(1, 0, 0, 0, 0, 1, d, 0, 0);
  endtask
  task automatic rd1(input logic [4:0] a);
    step(1, 1, a, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int cnt_exp[9] = '{0, 0, 1, 2, 2, 3, 3, 3, 3};

  initial begin
    // Reset held with an active read.
    rst = 1;
    step(1, 1, 5, 1, 5, 1, 5, 0, 0);
    step(1, 1, 5, 1, 5, 1, 5, 0, 0);
    chk("rst_stall", int'(stall_o), 0);
    chk("rst_hazard", int'(hazard_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_cnt", int'(stall_cnt_o), 0);
    @(posedge clk); #1; rst = 0;
    idle();

    // Distance-1 RAW: two stall cycles, then issue.
    wr(5);
    rd1(5);
    chk("d1_c1_stall", int'(stall_o), 7);
    chk("d1_c1_haz", int'(hazard_o), 1);
    rd1(5);
    chk("d1_c2_stall", int'(stall_o), 7);
    rd1(5);
    chk("d1_c3_issue", int'(issue_o), 1);
    chk("d1_c3_haz", int'(hazard_o), 0);
    chk("d1_cnt", int'(stall_cnt_o), 2);

    // Distance-2 RAW: one stall cycle.
    wr(7);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 7, 0, 0, 0, 0);
    chk("d2_haz", int'(hazard_o), 1);
    step(1, 0, 0, 1, 7, 0, 0, 0, 0);
    chk("d2_issue", int'(issue_o), 1);
    chk("d2_cnt", int'(stall_cnt_o), 3);
    // r0 never stalls.
    wr(0);
    rd1(0);
    chk("r0_haz", int'(hazard_o), 0);
    chk("r0_issue", int'(issue_o), 1);

    // External stall over a pending r5 hazard.
    wr(5);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 5, 0, 0, 0, 0, 1, 0);
      chk("ext_stall", int'(stall_o), 63);
      chk("ext_cnt", int'(stall_cnt_o), 3);
    end
    rd1(5);
    chk("ext_resume1", int'(hazard_o), 1);
    rd1(5);
    chk("ext_resume2", int'(hazard_o), 1);
    rd1(5);
    chk("ext_done", int'(issue_o), 1);
    chk("ext_cnt_after", int'(stall_cnt_o), 5);

    // Flush with r3, r4 pending.
    wr(3);
    wr(4);
    step(1, 1, 3, 0, 0, 0, 0, 0, 1);
    chk("fl_stall", int'(stall_o), 0);
    chk("fl_busy_before", int'(busy_o), 1);
    rd1(3);
    chk("fl_busy_after", int'(busy_o), 0);
    chk("fl_issue", int'(issue_o), 1);

    // Saturation of the 2-bit counter over five hazard cycles.
    @(posedge clk); #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    wr(1);
    chk("sat_0", int'(s_cnt), cnt_exp[0]);
    rd1(1);                                   // hazard 1
    chk("sat_1", int'(s_cnt), cnt_exp[1]);
    rd1(1);                                   // hazard 2
    chk("sat_2", int'(s_cnt), cnt_exp[2]);
    step(1, 1, 1, 0, 0, 1, 2, 0, 0);          // issue, writes r2
    chk("sat_3", int'(s_cnt), cnt_exp[3]);
    rd1(2);                                   // hazard 3
    chk("sat_4", int'(s_cnt), cnt_exp[4]);
    rd1(2);                                   // hazard 4
    chk("sat_5", int'(s_cnt), cnt_exp[5]);
    step(1, 1, 2, 0, 0, 1, 3, 0, 0);          // issue, writes r3
    chk("sat_6", int'(s_cnt), cnt_exp[6]);
    rd1(3);                                   // hazard 5
    chk("sat_7", int'(s_cnt), cnt_exp[7]);
    idle();
    chk("sat_8", int'(s_cnt), cnt_exp[8]);
    chk("sat_wide", int'(stall_cnt_o), 5);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst            = ($urandom_range(0, 99) < 2);
      id_valid_i     = ($urandom_range(0, 9) < 8);
      reg1_read_i    = $urandom_range(0, 1);
      reg1_addr_i    = 5'($urandom_range(0, 7));
      reg2_read_i    = $urandom_range(0, 1);
      reg2_addr_i    = 5'($urandom_range(0, 7));
      wreg_i         = ($urandom_range(0, 9) < 7);
      wd_i           = 5'($urandom_range(0, 7));
      stallreq_ext_i = ($urandom_range(0, 9) == 0);
      flush_i        = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end

    @(posedge clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
